key_tone_player: RTL and testbench
==================================

# key_tone_player

Downstream consumer of the key debouncer: takes its N one-cycle key pulses (active-high, one bit per key, do–si), selects a note, and drives the passive beeper with a square wave of that note's pitch for a fixed duration. Sits between the debouncer and the beeper pin. It also reports the current note index and a busy flag for display logic.

## Interface
- N, 7, number of keys / notes; key bit i maps to note i+1 (C4 D4 E4 F4 G4 A4 B4)
- CLK_HZ, 25_000_000, system clock frequency in Hz
- DUR_CYC, 12_500_000, note length in clock cycles (0.5 s at default)
- GAP_CYC, 1_250_000, silent gap length in cycles (used only with KEY_TONE_GAP_EN)
- HP_W, 20, width of half-period counter
- cp  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- key_pulse  in  N  debounced one-cycle press pulses, active-high
- beep  out  1  square-wave drive to beeper
- note_idx  out  3  current note 1..7, 0 when silent
- busy  out  1  high while in PLAY (or GAP)

## Operation
- States: IDLE, PLAY, GAP (GAP exists only with macro).
- Key select: lowest set bit of key_pulse wins on simultaneous pulses; higher bits ignored that cycle.
- IDLE: beep=0, note_idx=0, busy=0. Any key_pulse bit -> PLAY with latched note, duration counter=0, tone counter=0.
- PLAY: tone counter counts 0..HP-1, at HP-1 toggles beep and wraps to 0; duration counter increments each cycle; at DUR_CYC-1 -> IDLE (beep forced 0 same edge).
- Half period HP = CLK_HZ/(2*freq) truncated, clamped to >=1; freq table 262,294,330,349,392,440,494 Hz.
- Retrigger: key_pulse during PLAY restarts PLAY with new note (same note also restarts); both counters cleared, beep cleared.
- Pulse on same cycle as duration expiry: retrigger wins, no IDLE cycle.
- N>7 not supported; bits above 6 ignored.
- Reset mid-note: all state to reset values immediately; beep=0 asynchronously.

## Timing
- Reset values: beep=0, note_idx=0, busy=0, state IDLE, counters 0.
- Pulse sampled at edge k: busy=1 and note_idx valid after edge k; first beep rise after edge k+HP.
- Square-wave period 2*HP cycles, exact; duty 50%.
- Note occupies exactly DUR_CYC cycles with busy=1, then busy=0 after edge k+DUR_CYC.
- All outputs registered; no combinational path from key_pulse to outputs.

## Configuration
- KEY_TONE_GAP_EN defined: retrigger during PLAY and natural expiry both pass through GAP for GAP_CYC cycles (beep=0, busy=1, note_idx=0); a pulse arriving during PLAY or GAP is held in a one-deep pending register (latest wins) and played when GAP ends; with no pending note GAP -> IDLE.
- Not defined: no GAP state, no pending register; retrigger is immediate as in Operation.

## Structure
- Package key_tone_pkg: NOTE_NUM=7, note frequency constants, state enum typedef, function note_half_period(idx, clk_hz) returning HP_W bits.
- Sub-module tone_div: loadable half-period counter with clear, emitting the toggling square wave; the player FSM instantiates one.

## Test plan
- Bench CLK_HZ=1_000_000, DUR_CYC=10_000, GAP_CYC=500.
- Reset, no input -> beep=0, note_idx=0, busy=0 for 1000 cycles.
- Pulse bit5 (A4) -> note_idx=6, beep period 2272 cycles (HP=1136), busy high exactly 10_000 cycles, then beep=0.
- Pulses bit0 and bit3 same cycle -> note_idx=1, HP=1908 (C4).
- Bit2 at t, bit4 at t+3000 -> note changes to 5 at t+3000, counters restart, busy continuous to t+13_000; with KEY_TONE_GAP_EN: 500-cycle silent gap, then note 5 for 10_000 cycles.
- Assert rst low at t+4000 mid-note -> beep, busy, note_idx 0 immediately; after release stays IDLE until next pulse.
- Pulse on expiry cycle (t+9999) -> no idle cycle, new note starts, busy stays 1.

Source files
------------

// File: rtl/key_tone_pkg.sv
// Shared constants, state encoding and pitch helper for the key tone player.
package key_tone_pkg;

  localparam int NOTE_NUM  = 7;
  localparam int NOTE_HP_W = 20;

  localparam int F_C4 = 262;
  localparam int F_D4 = 294;
  localparam int F_E4 = 330;
  localparam int F_F4 = 349;
  localparam int F_G4 = 392;
  localparam int F_A4 = 440;
  localparam int F_B4 = 494;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} kt_state_e;

  function automatic int note_freq(input logic [2:0] idx);
    case (idx)
      3'd1:    return F_C4;
      3'd2:    return F_D4;
      3'd3:    return F_E4;
      3'd4:    return F_F4;
      3'd5:    return F_G4;
      3'd6:    return F_A4;
      3'd7:    return F_B4;
      default: return 0;
    endcase
  endfunction

  // Truncated half period in clock cycles, never below 1 so the divider always toggles.
  function automatic logic [NOTE_HP_W-1:0] note_half_period(input logic [2:0] idx, input int clk_hz);
    int f;
    int hp;
    f  = note_freq(idx);
    hp = (f == 0) ? 1 : clk_hz / (2 * f);
    if (hp < 1) hp = 1;
    return NOTE_HP_W'(hp);
  endfunction

endpackage

// File: rtl/tone_div.sv
// Loadable half-period counter producing a 50% square wave; clr forces count and wave to 0.
module tone_div #(
  parameter int HP_W = 20
) (
  input  logic            cp,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [HP_W-1:0] hp,
  output logic            wave
);

  logic [HP_W-1:0] cnt;

  always_ff @(posedge cp or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (en) begin
      if (cnt >= hp - 1'b1) begin
        cnt  <= '0;
        wave <= ~wave;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_tone_player.sv
// Key pulse -> fixed-length square-wave note on the beeper.
// KEY_TONE_GAP_EN inserts a silent gap after every note and holds one pending key.
module key_tone_player
  import key_tone_pkg::*;
#(
  parameter int N       = 7,
  parameter int CLK_HZ  = 25_000_000,
  parameter int DUR_CYC = 12_500_000,
  parameter int GAP_CYC = 1_250_000,
  parameter int HP_W    = 20
) (
  input  logic         cp,
  input  logic         rst,
  input  logic [N-1:0] key_pulse,
  output logic         beep,
  output logic [2:0]   note_idx,
  output logic         busy
);

  localparam int CNT_MAX = (DUR_CYC > GAP_CYC) ? DUR_CYC : GAP_CYC;
  localparam int DW      = $clog2(CNT_MAX + 1);

  kt_state_e       state, state_n;
  logic [2:0]      note, note_n, sel;
  logic [DW-1:0]   dur, dur_n;
  logic            tone_clr, tone_en;
  logic [HP_W-1:0] hp_tab [8];
`ifdef KEY_TONE_GAP_EN
  logic [2:0]      pend, pend_n;
`endif

  // Elaboration-time pitch table; index 0 (silence) maps to the minimum half period.
  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_hp
      assign hp_tab[g] = HP_W'(note_half_period(3'(g), CLK_HZ));
    end
  endgenerate

  // Lowest set key wins; keys beyond the note table are ignored.
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i < NOTE_NUM && key_pulse[i]) sel = 3'(i + 1);
  end

  always_comb begin
    state_n  = state;
    note_n   = note;
    dur_n    = dur + 1'b1;
    tone_clr = 1'b0;
    tone_en  = 1'b0;
`ifdef KEY_TONE_GAP_EN
    pend_n   = pend;
`endif
    case (state)
      IDLE: begin
        dur_n    = '0;
        tone_clr = 1'b1;
        if (sel != 3'd0) begin
          state_n = PLAY;
          note_n  = sel;
        end
      end
      PLAY: begin
        tone_en = 1'b1;
`ifdef KEY_TONE_GAP_EN
        if (sel != 3'd0) pend_n = sel;
        if (sel != 3'd0 || dur == DW'(DUR_CYC - 1)) begin
          state_n  = GAP;
          note_n   = '0;
          dur_n    = '0;
          tone_clr = 1'b1;
        end
`else
        // A pulse on the expiry edge takes priority, so no idle cycle appears.
        if (sel != 3'd0) begin
          note_n   = sel;
          dur_n    = '0;
          tone_clr = 1'b1;
        end else if (dur == DW'(DUR_CYC - 1)) begin
          state_n  = IDLE;
          note_n   = '0;
          dur_n    = '0;
          tone_clr = 1'b1;
        end
`endif
      end
`ifdef KEY_TONE_GAP_EN
      GAP: begin
        tone_clr = 1'b1;
        if (sel != 3'd0) pend_n = sel;
        if (dur == DW'(GAP_CYC - 1)) begin
          dur_n = '0;
          if (pend_n != 3'd0) begin
            state_n = PLAY;
            note_n  = pend_n;
            pend_n  = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
`endif
      default: begin
        state_n  = IDLE;
        note_n   = '0;
        dur_n    = '0;
        tone_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge cp or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      note  <= '0;
      dur   <= '0;
`ifdef KEY_TONE_GAP_EN
      pend  <= '0;
`endif
    end else begin
      state <= state_n;
      note  <= note_n;
      dur   <= dur_n;
`ifdef KEY_TONE_GAP_EN
      pend  <= pend_n;
`endif
    end
  end

  tone_div #(.HP_W(HP_W)) u_tone_div (
    .cp   (cp),
    .rst  (rst),
    .clr  (tone_clr),
    .en   (tone_en),
    .hp   (hp_tab[note]),
    .wave (beep)
  );

  assign note_idx = note;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_key_tone_player.sv
// Event scoreboard bench for key_tone_player: every output change is matched against a queued expectation.
module tb_key_tone_player;

  localparam int CLK_HZ = 1_000_000;
  localparam int DUR    = 10_000;
  localparam int GAP    = 500;
  localparam int HP_C4  = 1908;
  localparam int HP_D4  = 1700;
  localparam int HP_E4  = 1515;
  localparam int HP_G4  = 1275;
  localparam int HP_A4  = 1136;
  localparam int HP_B4  = 1012;

  typedef struct packed {
    int         cyc;
    logic       beep;
    logic [2:0] note;
    logic       busy;
  } snap_t;

  logic       cp;
  logic       rst;
  logic [6:0] key_pulse;
  logic       beep;
  logic [2:0] note_idx;
  logic       busy;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  snap_t exp_q[$];

  key_tone_player #(
    .N(7), .CLK_HZ(CLK_HZ), .DUR_CYC(DUR), .GAP_CYC(GAP), .HP_W(20)
  ) dut (
    .cp(cp), .rst(rst), .key_pulse(key_pulse),
    .beep(beep), .note_idx(note_idx), .busy(busy)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;
  always @(posedge cp) cyc <= cyc + 1;

  function automatic void push(input int c, input logic b, input logic [2:0] n, input logic bz);
    exp_q.push_back('{cyc: c, beep: b, note: n, busy: bz});
  endfunction

  // Note starting at edge k: beep toggles every hp edges until stop cuts it off.
  function automatic void push_note(input int k, input int n, input int hp, input int stop);
    push(k, 1'b0, 3'(n), 1'b1);
    for (int j = 1; k + hp * j < stop; j++) push(k + hp * j, j[0], 3'(n), 1'b1);
  endfunction

  function automatic int push_end(input int stop);
`ifdef KEY_TONE_GAP_EN
    push(stop, 1'b0, 3'd0, 1'b1);
    push(stop + GAP, 1'b0, 3'd0, 1'b0);
    return stop + GAP;
`else
    push(stop, 1'b0, 3'd0, 1'b0);
    return stop;
`endif
  endfunction

  task automatic scoreboard_mon();
    snap_t prev, obs, e;
    prev = '0;
    forever begin
      @(negedge cp);
      obs = '{cyc: cyc, beep: beep, note: note_idx, busy: busy};
      if ({obs.beep, obs.note, obs.busy} !== {prev.beep, prev.note, prev.busy}) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL output_change: got cyc=%0d beep=%b note=%0d busy=%b, required no change",
                   obs.cyc, obs.beep, obs.note, obs.busy);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL output_event: got cyc=%0d beep=%b note=%0d busy=%b, required cyc=%0d beep=%b note=%0d busy=%b",
                     obs.cyc, obs.beep, obs.note, obs.busy, e.cyc, e.beep, e.note, e.busy);
          end
        end
        prev = obs;
      end
    end
  endtask

  // Drive bits so the DUT samples them on edge number target.
  task automatic pulse_at(input logic [6:0] bits, input int target);
    while (cyc + 1 < target) @(negedge cp);
    key_pulse = bits;
    @(negedge cp);
    key_pulse = '0;
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(negedge cp);
    checks++;
    if ({beep, note_idx, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 00000", {beep, note_idx, busy});
    end
    rst = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge cp);
      if ({beep, note_idx, busy} !== 5'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d active cycles, required 0", bad);
    end
  endtask

  task automatic test_single_note();
    int k, endc, busy_cnt;
    k = cyc + 3;
    push_note(k, 6, HP_A4, k + DUR);
    endc = push_end(k + DUR);
    pulse_at(7'b0100000, k);
    checks++;
    if ({beep, note_idx, busy} !== {1'b0, 3'd6, 1'b1}) begin
      errors++;
      $display("FAIL a4_start: got beep=%b note=%0d busy=%b, required beep=0 note=6 busy=1", beep, note_idx, busy);
    end
    busy_cnt = 1;
    while (cyc < endc + 5) begin
      @(negedge cp);
      if (busy) busy_cnt++;
    end
    checks++;
    if (busy_cnt != endc - k) begin
      errors++;
      $display("FAIL a4_busy_len: got %0d, required %0d", busy_cnt, endc - k);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL a4_drain: got %0d pending events, required 0", exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    int k, endc;
    k = cyc + 3;
    push_note(k, 1, HP_C4, k + DUR);
    endc = push_end(k + DUR);
    pulse_at(7'b0001001, k);
    checks++;
    if (note_idx !== 3'd1) begin
      errors++;
      $display("FAIL simul_note: got %0d, required 1", note_idx);
    end
    while (exp_q.size() != 0 && cyc < endc + 10) @(negedge cp);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_drain: got %0d pending events, required 0", exp_q.size());
    end
    repeat (10) @(negedge cp);
  endtask

  task automatic test_retrigger();
    int k, endc, lows;
    logic [2:0] want;
    k = cyc + 3;
    push_note(k, 3, HP_E4, k + 3000);
`ifdef KEY_TONE_GAP_EN
    push(k + 3000, 1'b0, 3'd0, 1'b1);
    push_note(k + 3000 + GAP, 5, HP_G4, k + 3000 + GAP + DUR);
    endc = push_end(k + 3000 + GAP + DUR);
    want = 3'd0;
`else
    push_note(k + 3000, 5, HP_G4, k + 3000 + DUR);
    endc = push_end(k + 3000 + DUR);
    want = 3'd5;
`endif
    pulse_at(7'b0000100, k);
    pulse_at(7'b0010000, k + 3000);
    checks++;
    if (note_idx !== want || busy !== 1'b1) begin
      errors++;
      $display("FAIL retrig_switch: got note=%0d busy=%b, required note=%0d busy=1", note_idx, busy, want);
    end
    lows = 0;
    while (cyc < endc - 1) begin
      @(negedge cp);
      if (!busy) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL retrig_busy_cont: got %0d idle cycles, required 0", lows);
    end
    while (exp_q.size() != 0 && cyc < endc + 10) @(negedge cp);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL retrig_drain: got %0d pending events, required 0", exp_q.size());
    end
    repeat (10) @(negedge cp);
  endtask

  task automatic test_reset_mid();
    int k, bad;
    k = cyc + 3;
    push_note(k, 2, HP_D4, k + 4001);
    push(k + 4001, 1'b0, 3'd0, 1'b0);
    pulse_at(7'b0000010, k);
    while (cyc < k + 4000) @(negedge cp);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({beep, note_idx, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got %b, required 00000", {beep, note_idx, busy});
    end
    repeat (3) @(negedge cp);
    rst = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge cp);
      if ({beep, note_idx, busy} !== 5'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_stay_idle: got %0d active cycles, required 0", bad);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_drain: got %0d pending events, required 0", exp_q.size());
    end
  endtask

  task automatic test_expiry_pulse();
    int k, e, endc;
    logic [2:0] want;
    k = cyc + 3;
    e = k + DUR;
    push_note(k, 7, HP_B4, e);
`ifdef KEY_TONE_GAP_EN
    push(e, 1'b0, 3'd0, 1'b1);
    push_note(e + GAP, 1, HP_C4, e + GAP + DUR);
    endc = push_end(e + GAP + DUR);
    want = 3'd0;
`else
    push_note(e, 1, HP_C4, e + DUR);
    endc = push_end(e + DUR);
    want = 3'd1;
`endif
    pulse_at(7'b1000000, k);
    pulse_at(7'b0000001, e);
    checks++;
    if (busy !== 1'b1 || note_idx !== want) begin
      errors++;
      $display("FAIL expiry_retrig: got busy=%b note=%0d, required busy=1 note=%0d", busy, note_idx, want);
    end
    while (exp_q.size() != 0 && cyc < endc + 10) @(negedge cp);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL expiry_drain: got %0d pending events, required 0", exp_q.size());
    end
    repeat (10) @(negedge cp);
  endtask

  initial begin
    rst       = 1'b0;
    key_pulse = '0;
    fork
      scoreboard_mon();
    join_none
    test_reset();
    test_single_note();
    test_simultaneous();
    test_retrigger();
    test_reset_mid();
    test_expiry_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
